load_store_unit: RTL and testbench

//  Sits between the datapath (ALU address / rt data) and data memory, converting byte/half/word

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_lane_align.sv | 77 +++++++
 rtl/load_store_unit.sv | 216 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg - shared definitions for the load/store unit.
//   Access-size encodings (SZ_BYTE/SZ_HALF/SZ_WORD, SZ_BAD is the illegal code),
//   FSM state encoding (IDLE=0, MERGE=1) and the byte-lane mask helper used by
//   the store-merge path.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } lsu_state_e;

    // Byte lanes touched by an access of the given size starting at lane.
    // Half accesses pick the upper pair when lane[1] is set; an illegal size
    // touches nothing.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << lane;
            SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align - purely combinational lane steering for the load/store unit.
//   Load path : picks the addressed byte/half/word out of a memory word and
//               sign- or zero-extends it to 32 bits.
//   Store path: replaces the addressed lane(s) of an old memory word with the
//               right-justified store data.
// Ports:
//   i_rd_word    32  memory word (load source / merge base)
//   i_lane        2  byte lane of the access (already aligned for half/word)
//   i_size        2  access size code
//   i_signed      1  1 = sign-extend loads
//   i_wdata      32  right-justified store data
//   o_load_data  32  extended load result
//   o_merge_word 32  old word with the addressed lanes replaced
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rd_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_mask;
    logic [31:0] w_wrep;

    // Load extract and extension.
    always_comb begin
        w_byte      = 8'h00;
        w_half      = 16'h0000;
        o_load_data = 32'h0000_0000;
        case (i_lane)
            2'd0:    w_byte = i_rd_word[7:0];
            2'd1:    w_byte = i_rd_word[15:8];
            2'd2:    w_byte = i_rd_word[23:16];
            2'd3:    w_byte = i_rd_word[31:24];
            default: w_byte = 8'h00;
        endcase
        if (i_lane[1]) begin
            w_half = i_rd_word[31:16];
        end else begin
            w_half = i_rd_word[15:0];
        end
        case (i_size)
            SZ_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
            SZ_WORD: o_load_data = i_rd_word;
            default: o_load_data = 32'h0000_0000;
        endcase
    end

    // Store merge: replicate the store data into every lane, then let the
    // lane mask decide which bytes come from it and which from the old word.
    always_comb begin
        w_mask       = lane_mask(i_size, i_lane);
        w_wrep       = 32'h0000_0000;
        o_merge_word = 32'h0000_0000;
        case (i_size)
            SZ_BYTE: w_wrep = {4{i_wdata[7:0]}};
            SZ_HALF: w_wrep = {2{i_wdata[15:0]}};
            SZ_WORD: w_wrep = i_wdata;
            default: w_wrep = 32'h0000_0000;
        endcase
        for (int k = 0; k < 4; k++) begin
            if (w_mask[k]) begin
                o_merge_word[8*k +: 8] = w_wrep[8*k +: 8];
            end else begin
                o_merge_word[8*k +: 8] = i_rd_word[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit - converts byte/half/word loads and stores from the datapath
//   into accesses on a word-indexed data memory (combinational read, write at
//   posedge). Sub-word stores use a 2-cycle read-modify-write (IDLE -> MERGE).
//   Responses (rsp_valid/rsp_err/rsp_rdata) are registered.
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined     - misaligned half/word accesses return rsp_err
//   not defined - low address bits are masked and the access proceeds
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_we/req_size/req_signed/req_addr/req_wdata - request
//   rsp_valid/rsp_err/rsp_rdata - one-cycle response pulse
//   mem_we/mem_a/mem_wd/mem_rd  - data memory (mem_a is a word index)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);

    lsu_state_e  r_state;
    lsu_state_e  w_state_nxt;

    logic [AW-1:0] r_idx;
    logic [1:0]    r_lane;
    logic [1:0]    r_size;
    logic [31:0]   r_wdata;
    logic [31:0]   r_old;

    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [31:0]   r_rsp_rdata;

    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_mem_idx;
    logic [1:0]    w_lane;
    logic          w_misalign;
    logic          w_req_err;
    logic          w_mem_we;
    logic [31:0]   w_mem_wd;
    logic          w_latch;
    logic          w_rsp_valid_nxt;
    logic          w_rsp_err_nxt;
    logic [31:0]   w_rsp_rdata_nxt;

    logic [31:0]   w_al_rd;
    logic [1:0]    w_al_lane;
    logic [1:0]    w_al_size;
    logic [31:0]   w_al_wdata;
    logic [31:0]   w_load_data;
    logic [31:0]   w_merge_word;

    assign w_idx = req_addr[AW+1:2];

    // Alignment policy: either flag misalignment or silently clear the low bits.
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        w_lane     = req_addr[1:0];
        w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
        w_misalign = 1'b0;
        case (req_size)
            SZ_HALF: w_lane = {req_addr[1], 1'b0};
            SZ_WORD: w_lane = 2'b00;
            default: w_lane = req_addr[1:0];
        endcase
`endif
        w_req_err = (req_size == SZ_BAD) || (req_addr >= BYTE_LIMIT) || w_misalign;
    end

    // Lane steering sees the live request in IDLE and the latched one in MERGE.
    always_comb begin
        if (r_state == ST_MERGE) begin
            w_al_rd    = r_old;
            w_al_lane  = r_lane;
            w_al_size  = r_size;
            w_al_wdata = r_wdata;
        end else begin
            w_al_rd    = mem_rd;
            w_al_lane  = w_lane;
            w_al_size  = req_size;
            w_al_wdata = req_wdata;
        end
    end

    lsu_lane_align u_align (
        .i_rd_word    (w_al_rd),
        .i_lane       (w_al_lane),
        .i_size       (w_al_size),
        .i_signed     (req_signed),
        .i_wdata      (w_al_wdata),
        .o_load_data  (w_load_data),
        .o_merge_word (w_merge_word)
    );

    // Next-state, memory-side controls and next response values.
    always_comb begin
        w_state_nxt     = r_state;
        req_ready       = 1'b0;
        w_mem_we        = 1'b0;
        w_mem_wd        = 32'h0000_0000;
        w_mem_idx       = w_idx;
        w_latch         = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = 32'h0000_0000;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_req_err) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                    end else if (!req_we) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_rdata_nxt = w_load_data;
                    end else if (req_size == SZ_WORD) begin
                        w_mem_we        = 1'b1;
                        w_mem_wd        = req_wdata;
                        w_rsp_valid_nxt = 1'b1;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_MERGE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MERGE: begin
                w_mem_we        = 1'b1;
                w_mem_wd        = w_merge_word;
                w_mem_idx       = r_idx;
                w_rsp_valid_nxt = 1'b1;
                w_state_nxt     = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The write strobe is gated by reset so that a request driven while the
    // unit is held in reset can never reach memory.
    assign mem_we = w_mem_we & rst;
    assign mem_wd = rst ? w_mem_wd : 32'h0000_0000;
    assign mem_a  = {{(32-AW){1'b0}}, w_mem_idx};

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sub-word store context captured at accept for the MERGE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx   <= '0;
            r_lane  <= 2'b00;
            r_size  <= 2'b00;
            r_wdata <= 32'h0000_0000;
            r_old   <= 32'h0000_0000;
        end else if (w_latch) begin
            r_idx   <= w_idx;
            r_lane  <= w_lane;
            r_size  <= req_size;
            r_wdata <= req_wdata;
            r_old   <= mem_rd;
        end else begin
            r_idx   <= r_idx;
            r_lane  <= r_lane;
            r_size  <= r_size;
            r_wdata <= r_wdata;
            r_old   <= r_old;
        end
    end

    // Registered response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
        end else begin
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit - directed, table-driven bench for load_store_unit with a
// simple behavioural data memory. Honours LSU_MISALIGN_TRAP_EN when choosing
// expected values for misaligned accesses.
module tb_load_store_unit;
    import lsu_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:255];
    int          we_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH_WORDS(256), .AW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    assign mem_rd = mem[mem_a[7:0]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a[7:0]] <= mem_wd;
            we_cnt++;
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic [31:0] exp_mema;
        int          exp_wr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic err, input logic [31:0] rdata, input int lat,
                       input logic [31:0] mema, input int wr);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_err = err; v.exp_rdata = rdata; v.exp_lat = lat;
        v.exp_mema = mema; v.exp_wr = wr;
        vecs.push_back(v);
    endtask

    // One request, then wait (bounded) for its response.
    task automatic do_req(input vec_t v, output logic err, output logic [31:0] rdata,
                          output int lat, output logic [31:0] mema, output logic rdy0,
                          output logic rdy_after, output int wr);
        int wc0;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata;
        #1;
        mema = mem_a;
        rdy0 = req_ready;
        wc0  = we_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        lat = -1; err = 1'b0; rdata = 32'h0; rdy_after = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) rdy_after = req_ready;
            if (rsp_valid) begin
                lat = c; err = rsp_err; rdata = rsp_rdata;
                break;
            end
        end
        wr = we_cnt - wc0;
    endtask

    initial begin
        logic        g_err, g_rdy0, g_rdy1;
        logic [31:0] g_rdata, g_mema;
        int          g_lat, g_wr;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'hCAFE_F00D;
        mem[6] = 32'h0102_0304;

        //  we    size     sgn   addr          wdata          err   rdata           lat mema        wr
        add(1'b1, SZ_WORD, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,          1, 32'd4,   1);
        add(1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF,  1, 32'd4,   0);
        add(1'b1, SZ_WORD, 1'b0, 32'h0000_0010, 32'h1122_3344, 1'b0, 32'h0,          1, 32'd4,   1);
        add(1'b1, SZ_BYTE, 1'b0, 32'h0000_0011, 32'h1234_56AA, 1'b0, 32'h0,          2, 32'd4,   1);
        add(1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h1122_AA44,  1, 32'd4,   0);
        add(1'b0, SZ_BYTE, 1'b1, 32'h0000_0011, 32'h0,         1'b0, 32'hFFFF_FFAA,  1, 32'd4,   0);
        add(1'b0, SZ_BYTE, 1'b0, 32'h0000_0011, 32'h0,         1'b0, 32'h0000_00AA,  1, 32'd4,   0);
        add(1'b1, SZ_HALF, 1'b0, 32'h0000_0012, 32'hABCD_8001, 1'b0, 32'h0,          2, 32'd4,   1);
        add(1'b0, SZ_HALF, 1'b1, 32'h0000_0012, 32'h0,         1'b0, 32'hFFFF_8001,  1, 32'd4,   0);
        add(1'b0, SZ_HALF, 1'b1, 32'h0000_0010, 32'h0,         1'b0, 32'hFFFF_AA44,  1, 32'd4,   0);
        add(1'b0, SZ_HALF, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h0000_AA44,  1, 32'd4,   0);
        add(1'b1, SZ_WORD, 1'b0, 32'h0000_0400, 32'h1111_1111, 1'b1, 32'h0,          1, 32'd0,   0);
        add(1'b0, SZ_BAD,  1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'h0,          1, 32'd8,   0);
        add(1'b1, SZ_BAD,  1'b0, 32'h0000_0024, 32'h7777_7777, 1'b1, 32'h0,          1, 32'd9,   0);
        add(1'b0, SZ_WORD, 1'b0, 32'h0000_0002, 32'h0,         TRAP, TRAP ? 32'h0 : 32'hCAFE_F00D, 1, 32'd0, 0);
        add(1'b0, SZ_HALF, 1'b0, 32'h0000_0013, 32'h0,         TRAP, TRAP ? 32'h0 : 32'h0000_8001, 1, 32'd4, 0);
        add(1'b1, SZ_BYTE, 1'b0, 32'h0000_03FF, 32'h0000_005A, 1'b0, 32'h0,          2, 32'd255, 1);
        add(1'b0, SZ_WORD, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h5A00_0000,  1, 32'd255, 0);
        add(1'b0, SZ_BYTE, 1'b1, 32'h0000_03FF, 32'h0,         1'b0, 32'h0000_005A,  1, 32'd255, 0);
        add(1'b1, SZ_HALF, 1'b0, 32'h0000_03FD, 32'h0000_F00F, TRAP, 32'h0, TRAP ? 1 : 2, 32'd255, TRAP ? 0 : 1);
        add(1'b0, SZ_WORD, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, TRAP ? 32'h5A00_0000 : 32'h5A00_F00F, 1, 32'd255, 0);
        add(1'b0, SZ_BYTE, 1'b0, 32'h0000_0401, 32'h0,         1'b1, 32'h0,          1, 32'd0,   0);

        // Reset state, with a store request held up during reset.
        rst = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
        req_addr = 32'h0000_0010; req_wdata = 32'h5555_5555;
        repeat (2) @(negedge clk);
        chk("reset_mem_we", 0, {31'h0, mem_we}, 32'h0);
        chk("reset_rsp_valid", 0, {31'h0, rsp_valid}, 32'h0);
        chk("reset_rsp_err", 0, {31'h0, rsp_err}, 32'h0);
        chk("reset_rsp_rdata", 0, rsp_rdata, 32'h0);
        chk("reset_ready", 0, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        chk("reset_no_write", 0, mem[4], 32'h0);

        // Table of single transactions.
        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i], g_err, g_rdata, g_lat, g_mema, g_rdy0, g_rdy1, g_wr);
            chk("err", i, {31'h0, g_err}, {31'h0, vecs[i].exp_err});
            chk("rdata", i, g_rdata, vecs[i].exp_rdata);
            chk("latency", i, g_lat, vecs[i].exp_lat);
            chk("mem_a", i, g_mema, vecs[i].exp_mema);
            chk("ready_at_req", i, {31'h0, g_rdy0}, 32'h1);
            chk("ready_next", i, {31'h0, g_rdy1}, (vecs[i].exp_lat == 1) ? 32'h1 : 32'h0);
            chk("writes", i, g_wr, vecs[i].exp_wr);
        end
        chk("mem_word4", 0, mem[4], 32'h8001_AA44);

        // Back-to-back: store then load of the same word on consecutive accepts.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
        req_addr = 32'h0000_0020; req_wdata = 32'h0BAD_CAFE;
        @(posedge clk);
        #1;
        req_we = 1'b0; req_wdata = 32'h0;
        @(negedge clk);
        chk("b2b_store_rsp", 0, {31'h0, rsp_valid}, 32'h1);
        chk("b2b_ready", 0, {31'h0, req_ready}, 32'h1);
        chk("b2b_mem_a", 0, mem_a, 32'd8);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = 32'h0; req_size = 2'b00;
        @(negedge clk);
        chk("b2b_load_rsp", 0, {31'h0, rsp_valid}, 32'h1);
        chk("b2b_load_rdata", 0, rsp_rdata, 32'h0BAD_CAFE);
        @(negedge clk);
        chk("b2b_pulse_end", 0, {31'h0, rsp_valid}, 32'h0);

        // Reset asserted while a byte store sits in MERGE.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
        req_addr = 32'h0000_0018; req_wdata = 32'h0000_00FF;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_addr = 32'h0; req_wdata = 32'h0;
        chk("merge_ready", 0, {31'h0, req_ready}, 32'h0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_mem_we", 0, {31'h0, mem_we}, 32'h0);
        chk("abort_rsp_valid", 0, {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        chk("abort_ready", 0, {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        chk("abort_no_rsp", 0, {31'h0, rsp_valid}, 32'h0);
        chk("abort_mem_word", 0, mem[6], 32'h0102_0304);
        begin
            vec_t v;
            v.we = 1'b0; v.size = SZ_WORD; v.sgn = 1'b0; v.addr = 32'h0000_0018; v.wdata = 32'h0;
            v.exp_err = 1'b0; v.exp_rdata = 32'h0102_0304; v.exp_lat = 1; v.exp_mema = 32'd6; v.exp_wr = 0;
            do_req(v, g_err, g_rdata, g_lat, g_mema, g_rdy0, g_rdy1, g_wr);
            chk("abort_reload", 0, g_rdata, v.exp_rdata);
            chk("abort_reload_lat", 0, g_lat, v.exp_lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
